// File: rtl/sha_line_fetcher.sv
// sha_line_fetcher: fetches a run of 64-byte lines over AXI4 read bursts,
// buffers them in a first-word fall-through FIFO and streams them to the
// SHA core in address order. Bursts are only issued once FIFO space for
// every beat is reserved, so rready never has to drop mid-stream.
// Optional build macro: SHA_FETCH_BYTESWAP_EN (byte-reverse each 32-bit word
// of blk_data on the FIFO output).
module sha_line_fetcher #(
  parameter int ADDR_W     = 64,
  parameter int DATA_W     = 512,
  parameter int ID_W       = 16,
  parameter int AXI_ID     = 0,
  parameter int MAX_BURST  = 16,
  parameter int FIFO_DEPTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  // command / status
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [31:0]       num_lines,
  output logic              busy,
  output logic              done,
  output logic              err,
  // AXI read address channel
  output logic [ID_W-1:0]   arid,
  output logic [ADDR_W-1:0] araddr,
  output logic [7:0]        arlen,
  output logic [2:0]        arsize,
  output logic              arvalid,
  input  logic              arready,
  // AXI read data channel
  input  logic [ID_W-1:0]   rid,
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        rresp,
  input  logic              rlast,
  input  logic              rvalid,
  output logic              rready,
  // message block stream
  output logic [DATA_W-1:0] blk_data,
  output logic              blk_valid,
  input  logic              blk_ready
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;       // next burst address
  logic [31:0]       req_left_reg, req_left_next; // lines not yet requested
  logic [31:0]       pop_left_reg, pop_left_next; // lines not yet consumed
  logic [CNT_W-1:0]  outst_reg, outst_next;     // beats requested, not yet returned
  logic              err_reg, err_next;

  // FIFO storage and bookkeeping
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0]  count_reg;
  logic [DATA_W-1:0] fifo_out;

  logic              ar_fire, beat_fire, pop, push_ok, fifo_full;
  logic [6:0]        lines_to_4k;
  logic [31:0]       len_w;
  logic [6:0]        burst_len;
  logic [CNT_W-1:0]  credits;
  logic              credit_ok;

  // Signals the protocol tells us to ignore: beats are counted, not tagged.
  logic              unused_ok;
  assign unused_ok = ^{rid, rlast, base_addr[5:0]};

  assign ar_fire   = arvalid & arready;
  assign beat_fire = rvalid & rready;
  assign blk_valid = (count_reg != '0);
  assign pop       = blk_valid & blk_ready;
  assign fifo_full = (count_reg == CNT_W'(FIFO_DEPTH));
  assign push_ok   = beat_fire & (~fifo_full | pop);

  // Burst length: bounded by remaining lines, MAX_BURST and the 4 KB page.
  always_comb begin
    lines_to_4k = 7'd64 - {1'b0, addr_reg[11:6]};
    len_w       = req_left_reg;
    if (len_w > 32'(MAX_BURST)) len_w = 32'(MAX_BURST);
    if (len_w > {25'd0, lines_to_4k}) len_w = {25'd0, lines_to_4k};
    burst_len   = len_w[6:0];
  end

  // Free FIFO slots not already promised to an outstanding burst.
  assign credits   = CNT_W'(FIFO_DEPTH) - count_reg - outst_reg;
  assign credit_ok = ({{(32-CNT_W){1'b0}}, credits} >= len_w);

  assign arid   = ID_W'(AXI_ID);
  assign arsize = 3'd6;
  assign araddr = addr_reg;
  assign arlen  = arvalid ? 8'(burst_len - 7'd1) : 8'd0;
  assign err    = err_reg;

  // Control state register and transfer counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= S_IDLE;
      addr_reg     <= '0;
      req_left_reg <= '0;
      pop_left_reg <= '0;
      outst_reg    <= '0;
      err_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      addr_reg     <= addr_next;
      req_left_reg <= req_left_next;
      pop_left_reg <= pop_left_next;
      outst_reg    <= outst_next;
      err_reg      <= err_next;
    end
  end

  // Next-state logic and FSM-driven outputs.
  always_comb begin
    state_next    = state_reg;
    addr_next     = addr_reg;
    req_left_next = req_left_reg;
    pop_left_next = pop_left_reg;
    err_next      = err_reg;
    arvalid       = 1'b0;
    rready        = 1'b0;
    busy          = 1'b0;
    done          = 1'b0;

    if (pop) pop_left_next = pop_left_reg - 32'd1;
    if (beat_fire && (rresp != 2'b00)) err_next = 1'b1;

    case (state_reg)
      S_IDLE: begin
        if (start) begin
          addr_next     = {base_addr[ADDR_W-1:6], 6'b0};
          req_left_next = num_lines;
          pop_left_next = num_lines;
          err_next      = 1'b0;
          state_next    = (num_lines == 32'd0) ? S_DONE : S_ISSUE;
        end
      end
      S_ISSUE: begin
        busy    = 1'b1;
        rready  = 1'b1;
        arvalid = credit_ok;
        if (ar_fire) begin
          addr_next     = addr_reg + (ADDR_W'(burst_len) << 6);
          req_left_next = req_left_reg - len_w;
          if (req_left_reg == len_w) state_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        busy   = 1'b1;
        rready = 1'b1;
        if (pop_left_next == 32'd0) state_next = S_DONE;
      end
      S_DONE: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Outstanding beat count: grows by a burst on AR handshake, shrinks per beat.
  always_comb begin
    outst_next = outst_reg;
    if (ar_fire)   outst_next = outst_next + CNT_W'(burst_len);
    if (beat_fire) outst_next = outst_next - CNT_W'(1);
  end

  // FIFO pointers and occupancy; push and pop may coincide at any fill level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop)     rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      case ({push_ok, pop})
        2'b10:   count_reg <= count_reg + CNT_W'(1);
        2'b01:   count_reg <= count_reg - CNT_W'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  // Line storage write port; contents need no reset since occupancy gates use.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_reg] <= rdata;
  end

  // Fall-through read: the head entry is visible as soon as it is written.
  assign fifo_out = mem[rd_ptr_reg];

`ifdef SHA_FETCH_BYTESWAP_EN
  // Little-endian memory words become big-endian SHA words.
  for (genvar gi = 0; gi < DATA_W / 32; gi++) begin : g_swap
    assign blk_data[gi*32 +: 32] = {fifo_out[gi*32 +: 8],
                                    fifo_out[gi*32 + 8 +: 8],
                                    fifo_out[gi*32 + 16 +: 8],
                                    fifo_out[gi*32 + 24 +: 8]};
  end
`else
  assign blk_data = fifo_out;
`endif

endmodule

// File: tb/tb_sha_line_fetcher.sv
// Bench for sha_line_fetcher: AXI memory responder, consumer and a
// transaction-level model of the expected burst split and block order.
module tb_sha_line_fetcher;
  localparam int ADDR_W = 64;
  localparam int DATA_W = 512;
  localparam int ID_W   = 16;

  logic              clk, rst, start;
  logic [ADDR_W-1:0] base_addr;
  logic [31:0]       num_lines;
  logic              busy, done, err;
  logic [ID_W-1:0]   arid;
  logic [ADDR_W-1:0] araddr;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic              arvalid, arready;
  logic [ID_W-1:0]   rid;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast, rvalid, rready;
  logic [DATA_W-1:0] blk_data;
  logic              blk_valid, blk_ready;

  sha_line_fetcher dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .num_lines(num_lines), .busy(busy), .done(done), .err(err),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .rvalid(rvalid), .rready(rready),
    .blk_data(blk_data), .blk_valid(blk_valid), .blk_ready(blk_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // model / bookkeeping
  logic [63:0]  exp_ar_addr[$];
  logic [7:0]   exp_ar_len[$];
  logic [511:0] exp_blk[$];
  logic [63:0]  pend[$];
  int  ar_cnt, blk_cnt, done_cnt, beats_presented, beats_acc;
  int  lines_issued, popped, arv_cycles, busy_cycles;
  int  exp_n, exp_ar_total, d0_g, err_beat, r_limit;
  bit  exp_err, ar_rand, r_rand, b_rand, b_hold, r_hold, ar_wait;
  logic [63:0] ar_w_addr;
  logic [7:0]  ar_w_len;

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Memory contents: each line is a distinct function of its address.
  function automatic logic [511:0] line_raw(input logic [63:0] a);
    logic [511:0] d;
    for (int i = 0; i < 16; i++)
      d[i*32 +: 32] = a[31:0] ^ a[63:32] ^ (32'h9E37_0000 + 32'(i) * 32'h0101_0101);
    return d;
  endfunction

  function automatic logic [511:0] line_exp(input logic [63:0] a);
    logic [511:0] d;
    d = line_raw(a);
`ifdef SHA_FETCH_BYTESWAP_EN
    for (int i = 0; i < 16; i++)
      d[i*32 +: 32] = {d[i*32 +: 8], d[i*32+8 +: 8], d[i*32+16 +: 8], d[i*32+24 +: 8]};
`endif
    return d;
  endfunction

  // AXI slave + consumer: drive at negedge, observe 1 ns later.
  initial begin
    logic [63:0] a;
    arready = 0; rvalid = 0; rdata = '0; rresp = 0; rid = '0; rlast = 0; blk_ready = 0;
    r_hold = 0; ar_wait = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pend.delete(); rvalid = 0; r_hold = 0; ar_wait = 0;
        continue;
      end
      arready = ar_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      if (!r_hold) begin
        if (pend.size() > 0 && beats_presented < r_limit &&
            (!r_rand || $urandom_range(0, 2) != 0)) begin
          a      = pend.pop_front();
          rvalid = 1;
          rdata  = line_raw(a);
          rresp  = (beats_presented == err_beat) ? 2'd2 : 2'd0;
          rlast  = 0;
          beats_presented++;
        end else begin
          rvalid = 0;
        end
      end
      blk_ready = b_hold ? 1'b0 : (b_rand ? 1'($urandom_range(0, 1)) : 1'b1);
      #1;
      if (arvalid) arv_cycles++;
      if (busy) busy_cycles++;
      if (ar_wait) begin
        check("ar_hold_valid", arvalid, 1'b1);
        check("ar_hold_addr", araddr, ar_w_addr);
        check("ar_hold_len", arlen, ar_w_len);
      end
      if (arvalid && arready) begin
        ar_cnt++;
        if (exp_ar_addr.size() == 0) begin
          check("ar_extra", ar_cnt, exp_ar_total);
        end else begin
          check("araddr", araddr, exp_ar_addr.pop_front());
          check("arlen", arlen, exp_ar_len.pop_front());
        end
        check("arsize", arsize, 3'd6);
        check("arid", arid, 16'd0);
        lines_issued += int'(arlen) + 1;
        check("credit_bound", (lines_issued - popped) <= 32, 1'b1);
        for (int k = 0; k <= int'(arlen); k++) pend.push_back(araddr + 64'(k) * 64);
        ar_wait = 0;
        $display("AR  addr=%h len=%0d", araddr, arlen);
      end else begin
        ar_wait   = arvalid;
        ar_w_addr = araddr;
        ar_w_len  = arlen;
      end
      if (rvalid && rready) beats_acc++;
      r_hold = rvalid && !rready;
      if (blk_valid && blk_ready) begin
        blk_cnt++; popped++;
        if (exp_blk.size() == 0) check("blk_extra", blk_cnt, exp_n);
        else check("blk_data", blk_data, exp_blk.pop_front());
        $display("BLK #%0d data[31:0]=%h", blk_cnt, blk_data[31:0]);
      end
      if (done) begin
        done_cnt++;
        check("busy_low_at_done", busy, 1'b0);
        $display("DONE pulse %0d", done_cnt);
      end
    end
  end

  task automatic start_run(input logic [63:0] base, input int n,
                           input bit ar_r, input bit r_r, input bit b_r, input int eb);
    logic [63:0] a;
    int rem, len, l4k;
    exp_ar_addr.delete(); exp_ar_len.delete(); exp_blk.delete();
    a = {base[63:6], 6'b0};
    rem = n; exp_ar_total = 0;
    while (rem > 0) begin
      l4k = 64 - int'(a[11:6]);
      len = rem;
      if (len > 16) len = 16;
      if (len > l4k) len = l4k;
      exp_ar_addr.push_back(a);
      exp_ar_len.push_back(8'(len - 1));
      exp_ar_total++;
      a = a + 64'(len) * 64;
      rem -= len;
    end
    for (int i = 0; i < n; i++) exp_blk.push_back(line_exp({base[63:6], 6'b0} + 64'(i) * 64));
    @(negedge clk); #2;
    exp_n = n; exp_err = (eb >= 0 && eb < n);
    ar_rand = ar_r; r_rand = r_r; b_rand = b_r; err_beat = eb;
    beats_presented = 0; beats_acc = 0; lines_issued = 0; popped = 0;
    ar_cnt = 0; blk_cnt = 0; arv_cycles = 0; busy_cycles = 0; d0_g = done_cnt;
    start = 1; base_addr = base; num_lines = n;
    @(negedge clk); #2;
    start = 0;
    check("busy_t1", busy, n != 0);
    check("done_t1", done, n == 0);
    check("arvalid_t1", arvalid, n != 0);
    check("err_cleared", err, 1'b0);
  endtask

  task automatic finish_run(input string tag);
    for (int c = 0; c < 3000 && done_cnt == d0_g; c++) @(negedge clk);
    repeat (2) @(negedge clk);
    #2;
    check({tag, "_done_once"}, done_cnt - d0_g, 1);
    check({tag, "_blocks"}, blk_cnt, exp_n);
    check({tag, "_ars"}, ar_cnt, exp_ar_total);
    check({tag, "_blk_left"}, exp_blk.size(), 0);
    check({tag, "_err"}, err, exp_err);
    check({tag, "_busy_end"}, busy, 1'b0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1; start = 0; base_addr = '0; num_lines = '0;
    ar_rand = 0; r_rand = 0; b_rand = 0; b_hold = 0; err_beat = -1; r_limit = 1 << 30;
    done_cnt = 0; ar_cnt = 0; blk_cnt = 0; beats_presented = 0; beats_acc = 0;
    repeat (3) @(negedge clk);
    check("rst_arvalid", arvalid, 1'b0);
    check("rst_rready", rready, 1'b0);
    check("rst_blk_valid", blk_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_araddr", araddr, 64'd0);
    check("rst_arlen", arlen, 8'd0);
    check("rst_arid", arid, 16'd0);
    check("rst_arsize", arsize, 3'd6);
    #2 rst = 0;

    // aligned single burst
    start_run(64'h1000, 4, 0, 0, 0, -1);
    finish_run("basic4");

    // 4 KB boundary split
    start_run(64'h1FC0, 3, 0, 0, 0, -1);
    finish_run("cross4k");

    // credit stall with a blocked consumer
    b_hold = 1;
    start_run(64'h10000, 40, 0, 0, 0, -1);
    repeat (100) @(negedge clk);
    #2;
    check("stall_ars", ar_cnt, 2);
    check("stall_arvalid", arvalid, 1'b0);
    check("stall_blocks", blk_cnt, 0);
    b_hold = 0;
    finish_run("credit40");

    // zero-length command
    start_run(64'h5000, 0, 0, 0, 0, -1);
    finish_run("zero");
    check("zero_no_arvalid", arv_cycles, 0);
    check("zero_no_busy", busy_cycles, 0);

    // error response on one beat, sticky until next start
    start_run(64'h4000, 4, 0, 0, 0, 1);
    finish_run("rresp_err");
    repeat (3) @(negedge clk);
    #2 check("err_sticky", err, 1'b1);
    start_run(64'h4100, 2, 0, 0, 0, -1);
    finish_run("after_err");

    // address wrap at the top of the address space
    start_run(64'hFFFF_FFFF_FFFF_FF80, 5, 1, 1, 1, -1);
    finish_run("wrap");

    // randomized runs
    for (int r = 0; r < 8; r++) begin
      logic [63:0] b;
      b = {$urandom, $urandom};
      if (r[0]) b[11:6] = 6'(64 - $urandom_range(1, 20));
      start_run(b, $urandom_range(1, 70), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1);
      finish_run("random");
    end

    // reset in the middle of a transfer with 5 lines buffered
    b_hold = 1; r_limit = 5;
    start_run(64'h2000, 8, 0, 0, 0, -1);
    for (int c = 0; c < 200 && beats_acc < 5; c++) @(negedge clk);
    repeat (3) @(negedge clk);
    check("pre_rst_blk_valid", blk_valid, 1'b1);
    #2 rst = 1;
    #1;
    check("mid_rst_arvalid", arvalid, 1'b0);
    check("mid_rst_rready", rready, 1'b0);
    check("mid_rst_blk_valid", blk_valid, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_done", done, 1'b0);
    check("mid_rst_araddr", araddr, 64'd0);
    check("mid_rst_arlen", arlen, 8'd0);
    repeat (2) @(negedge clk);
    b_hold = 0; r_limit = 1 << 30;
    exp_blk.delete(); exp_ar_addr.delete(); exp_ar_len.delete();
    #2 rst = 0;
    start_run(64'h3000, 2, 0, 0, 0, -1);
    finish_run("post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
